// File: rtl/ft_pkg.sv
// Definitions shared by the ADC front end, the SPI status logic and the Goertzel bank.
// The capture FSM encoding and the offset-binary zero code live here.
package ft_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_ARMED = 2'd1,
        CAP_RUN   = 2'd2,
        CAP_DONE  = 2'd3
    } cap_state_t;

    localparam int               ADC_DW   = 8;
    localparam logic [ADC_DW-1:0] ADC_ZERO = 8'h80;

    // STATUS register bit reporting that a capture run has completed.
    localparam logic [7:0] STATUS_CAP_DONE_MASK = 8'h01;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser for an asynchronous level plus a registered rising-edge flag.
// The level and rise outputs change on the same clock edge, so a consumer sees both together.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic srst,
    input  logic d,
    output logic level,
    output logic rise
);

    // A single flop is not a synchroniser; clamp to two stages.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;
    logic         rise_q;
    logic         rise_d;

    // Shift chain and edge flag; the edge is taken from the value about to enter the last stage.
    always_comb begin
        if (srst) begin
            sync_d = {N{1'b0}};
            rise_d = 1'b0;
        end else begin
            sync_d = {sync_q[N-2:0], d};
            rise_d = sync_q[N-2] & ~sync_q[N-1];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {N{1'b0}};
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign level = sync_q[N-1];
    assign rise  = rise_q;

endmodule

// File: rtl/sample_capture.sv
// ADC capture stage: synchronises adc_en, converts offset-binary samples to signed fixed point
// and streams exactly num_samp samples per run to the Goertzel bank with done/busy status.
module sample_capture
    import ft_pkg::*;
#(
    parameter int DW_IN       = 8,
    parameter int DW_OUT      = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              soft_rst,
    input  logic              start,
    input  logic              mode,
    input  logic [CNT_W-1:0]  num_samp,
    input  logic              adc_en,
    input  logic [DW_IN-1:0]  adc_data,
    output logic [DW_OUT-1:0] s_data,
    output logic              s_valid,
    output logic              s_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  samp_cnt
);

    localparam logic [DW_IN-1:0] ZERO_CODE = DW_IN'(ADC_ZERO) << (DW_IN - ADC_DW);

    // Flipping the MSB maps offset binary onto two's complement; then left-align into DW_OUT.
    function automatic logic [DW_OUT-1:0] to_signed(input logic [DW_IN-1:0] raw);
        return DW_OUT'(raw ^ ZERO_CODE) << (DW_OUT - DW_IN);
    endfunction

    logic [1:0]        rst_sync_q;
    logic [1:0]        rst_sync_d;
    logic              rst_n_int;
    logic              en_level_s;
    logic              en_rise_s;
    logic              take_s;

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  num_d;
    logic              mode_q;
    logic              mode_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DW_OUT-1:0] data_q;
    logic [DW_OUT-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              last_q;
    logic              last_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;

    // Reset release is re-timed to clk so every flop leaves reset on the same edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchroniser: asserts immediately with rstn, deasserts two clocks later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_en_sync (
        .clk   (clk),
        .rstn  (rst_n_int),
        .srst  (soft_rst),
        .d     (adc_en),
        .level (en_level_s),
        .rise  (en_rise_s)
    );

    // Capture FSM, sample counter and stream outputs.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = (state_q == CAP_ARMED) || (state_q == CAP_RUN);
        done_d  = (state_q == CAP_DONE);
        take_s  = 1'b0;

        case (state_q)
            CAP_IDLE: begin
                if (start) begin
                    num_d  = num_samp;
                    mode_d = mode;
                    cnt_d  = {CNT_W{1'b0}};
                    if (num_samp == {CNT_W{1'b0}}) begin
                        state_d = CAP_DONE;
                    end else begin
                        state_d = CAP_ARMED;
                    end
                end else begin
                    state_d = CAP_IDLE;
                end
            end
            // Only a fresh edge may open a run, whatever the mode, so it never starts mid-strobe.
            CAP_ARMED: take_s = en_rise_s;
            CAP_RUN:   take_s = mode_q ? en_level_s : en_rise_s;
            CAP_DONE:  state_d = CAP_IDLE;
            default:   state_d = CAP_IDLE;
        endcase

        // cnt_q is always below num_q here, so the increment cannot wrap even at the maximum count.
        if (take_s) begin
            valid_d = 1'b1;
            data_d  = to_signed(adc_data);
            cnt_d   = cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == num_q) begin
                last_d  = 1'b1;
                state_d = CAP_DONE;
            end else begin
                state_d = CAP_RUN;
            end
        end else begin
            data_d = data_q;
        end

        if (soft_rst) begin
            state_d = CAP_IDLE;
            num_d   = {CNT_W{1'b0}};
            mode_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
            data_d  = {DW_OUT{1'b0}};
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            busy_d = busy_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= CAP_IDLE;
            num_q   <= {CNT_W{1'b0}};
            mode_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= {DW_OUT{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_data   = data_q;
    assign s_valid  = valid_q;
    assign s_last   = last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign samp_cnt = cnt_q;

endmodule
